// File: rtl/reaction_pkg.sv
// Shared state encoding and LFSR constants for the reaction-time controller.
// Optional best-time tracking is enabled by REACTION_BEST_TIME_EN.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    GO     = 3'd2,
    RESULT = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 seen from a right-shifting register: bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/reaction_delay_lfsr.sv
// Free-running LFSR and random GO-delay countdown in timing ticks.
// zero flags that the loaded delay has fully elapsed.
module reaction_delay_lfsr
  import reaction_pkg::*;
#(
  parameter int DELAY_MIN       = 1000,
  parameter int DELAY_SPAN_LOG2 = 12,
  parameter int DLY_W           = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [15:0]      lfsr;
  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] load_val;

  assign load_val = DLY_W'(DELAY_MIN)
                  + DLY_W'(lfsr[DELAY_SPAN_LOG2-1:0]);
  assign zero = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - DLY_W'(1);
    end
  end

endmodule

// File: rtl/reaction_multi_fsm.sv
// N-player reaction-time controller: FSM, tick prescaler, elapsed timer.
// Define REACTION_BEST_TIME_EN to add best_time / new_best outputs.
module reaction_multi_fsm
  import reaction_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int TIME_W          = 14,
  parameter int MAX_TIME        = 9999,
  parameter int CLK_PER_TICK    = 50000,
  parameter int DELAY_MIN       = 1000,
  parameter int DELAY_SPAN_LOG2 = 12,
  parameter int PID_W =
    (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_btn,
  input  logic [NUM_PLAYERS-1:0] react_btn,
  output logic                   led,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic                   timeout,
  output logic [PID_W-1:0]       player_id,
  output logic                   tie,
  output logic [TIME_W-1:0]      result_time,
`ifdef REACTION_BEST_TIME_EN
  output logic [TIME_W-1:0]      best_time,
  output logic                   new_best,
`endif
  output logic [2:0]             state_out
);

  localparam int PRE_W = $clog2(CLK_PER_TICK);
  localparam int DLY_W =
    $clog2(DELAY_MIN + (1 << DELAY_SPAN_LOG2) + 1);
  localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);

  state_t state, next_state;

  logic                   start_prev;
  logic [NUM_PLAYERS-1:0] react_prev;
  logic                   edge_en;
  logic                   start_edge;
  logic [NUM_PLAYERS-1:0] react_edge;
  logic                   any_react;
  logic                   multi;
  logic [PID_W-1:0]       win_id;

  logic [PRE_W-1:0]  pre;
  logic              tick;
  logic [TIME_W-1:0] elapsed;
  logic              at_max;
  logic              dly_load;
  logic              dly_zero;
  logic              enter_timed;

  // Edges are masked for one cycle after reset so held buttons stay quiet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b0;
      react_prev <= '0;
      edge_en    <= 1'b0;
    end else begin
      start_prev <= start_btn;
      react_prev <= react_btn;
      edge_en    <= 1'b1;
    end
  end

  assign start_edge = edge_en & start_btn & ~start_prev;
  assign react_edge = {NUM_PLAYERS{edge_en}}
                    & react_btn & ~react_prev;
  assign any_react  = |react_edge;
  assign multi = |(react_edge & (react_edge - NUM_PLAYERS'(1)));

  always_comb begin
    win_id = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (react_edge[i]) win_id = PID_W'(i);
    end
  end

  assign tick   = (pre == PRE_W'(CLK_PER_TICK - 1));
  assign at_max = (elapsed == MAX_T);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start_edge) next_state = ARM;
      end
      ARM: begin
        if (any_react)     next_state = FAULT;
        else if (dly_zero) next_state = GO;
      end
      GO: begin
        if (any_react || at_max) next_state = RESULT;
      end
      RESULT, FAULT: begin
        if (start_edge) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign dly_load    = (state == IDLE) && start_edge;
  assign enter_timed = (next_state != state)
                    && (next_state == ARM || next_state == GO);

  reaction_delay_lfsr #(
    .DELAY_MIN       (DELAY_MIN),
    .DELAY_SPAN_LOG2 (DELAY_SPAN_LOG2),
    .DLY_W           (DLY_W)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .load  (dly_load),
    .dec   (tick && state == ARM),
    .zero  (dly_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (enter_timed || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elapsed <= '0;
    end else if (state == ARM && next_state == GO) begin
      elapsed <= '0;
    end else if (state == GO && tick && !at_max) begin
      elapsed <= elapsed + TIME_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      led         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      timeout     <= 1'b0;
      player_id   <= '0;
      tie         <= 1'b0;
      result_time <= '0;
    end else begin
      state <= next_state;
      led   <= (next_state == GO);
      busy  <= (next_state == ARM) || (next_state == GO);
      done  <= (next_state == RESULT);
      fault <= (next_state == FAULT);
      if (dly_load) begin
        timeout     <= 1'b0;
        player_id   <= '0;
        tie         <= 1'b0;
        result_time <= '0;
      end else if (state == ARM && any_react) begin
        player_id <= win_id;
        tie       <= multi;
      end else if (state == GO && any_react) begin
        player_id   <= win_id;
        tie         <= multi;
        result_time <= elapsed;
        timeout     <= 1'b0;
      end else if (state == GO && at_max) begin
        timeout     <= 1'b1;
        result_time <= MAX_T;
      end
    end
  end

`ifdef REACTION_BEST_TIME_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_time <= MAX_T;
      new_best  <= 1'b0;
    end else begin
      new_best <= 1'b0;
      if (state == GO && any_react && elapsed < best_time) begin
        best_time <= elapsed;
        new_best  <= 1'b1;
      end
    end
  end
`endif

  assign state_out = state;

endmodule
